srl_fifo_ctrl: RTL

Control block that sequences an external addressable shift register (SRL storage: write enable shifts entry i to i+1, combinational read at `addr`) into a first-word-fall-through FIFO with a registered output stage. It sits between two dataflow processes, such as start-token and data-drain channels feeding the systolic-array processes. It owns every `we`/`addr` decision for the storage, the occupancy count, the full/empty handshake flags, and the output register.

---
 rtl/srl_fifo_ctrl_if.sv | 25 ++
 rtl/srl_fifo_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/srl_fifo_ctrl_if.sv
// FIFO-side handshake bundle for srl_fifo_ctrl.
// The write side (producer) and the read side (consumer) both sit on the master modport.
// The controller uses the slave modport.
interface srl_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;

    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n
    );

    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n
    );
endinterface

// File: rtl/srl_fifo_ctrl.sv
// Sequencing control for an external addressable shift register.
// Together they form a first-word-fall-through FIFO.
// The head word lives in a local output register.
// The remaining words live in the SRL: newest at index 0, oldest at index sr_cnt-1.
module srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    srl_fifo_ctrl_if.slave        fifo,
    output logic [ADDR_WIDTH:0]   num_data_valid,
    output logic                  sr_we,
    output logic [ADDR_WIDTH-1:0] sr_addr,
    output logic [DATA_WIDTH-1:0] sr_din,
    input  logic [DATA_WIDTH-1:0] sr_dout
);

    typedef enum logic [1:0] {EMPTY, ONE, MORE} state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_INC = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   NUM_INC = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   NUM_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] sr_cnt, sr_cnt_nx;
    logic [ADDR_WIDTH:0]   num_nx;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  full_n_q, empty_n_q;
    logic                  push, pop, we, ld_byp, ld_sr;

    assign push = fifo.if_write & fifo.if_write_ce & full_n_q;
    assign pop  = fifo.if_read & fifo.if_read_ce & empty_n_q;

    assign sr_din          = fifo.if_din;
    assign sr_addr         = (sr_cnt != '0) ? sr_cnt - CNT_INC : '0;
    assign sr_we           = we & ap_rst_n;
    assign fifo.if_dout    = dout_q;
    assign fifo.if_full_n  = full_n_q;
    assign fifo.if_empty_n = empty_n_q;

    // Next state, SRL write enable and output-register load selection.
    always_comb begin
        state_nx  = state;
        sr_cnt_nx = sr_cnt;
        we        = 1'b0;
        ld_byp    = 1'b0;
        ld_sr     = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    ld_byp   = 1'b1;
                    state_nx = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    we        = 1'b1;
                    sr_cnt_nx = CNT_INC;
                    state_nx  = MORE;
                end else if (pop && !push) begin
                    state_nx = EMPTY;
                end else if (push && pop) begin
                    // The head leaves and the new word goes straight into its place.
                    ld_byp = 1'b1;
                end
            end
            MORE: begin
                if (push && !pop) begin
                    we        = 1'b1;
                    sr_cnt_nx = sr_cnt + CNT_INC;
                end else if (pop && !push) begin
                    ld_sr     = 1'b1;
                    sr_cnt_nx = sr_cnt - CNT_INC;
                    if (sr_cnt == CNT_INC) state_nx = ONE;
                end else if (push && pop) begin
                    // sr_dout is read from the pre-shift oldest index at the same edge as the shift.
                    we    = 1'b1;
                    ld_sr = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // Total occupancy moves by at most one per cycle.
    always_comb begin
        num_nx = num_data_valid;
        if (push && !pop)      num_nx = num_data_valid + NUM_INC;
        else if (pop && !push) num_nx = num_data_valid - NUM_INC;
    end

    // State, counters, registered flags and the head-word register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state          <= EMPTY;
            sr_cnt         <= '0;
            num_data_valid <= '0;
            full_n_q       <= 1'b1;
            empty_n_q      <= 1'b0;
            dout_q         <= '0;
        end else begin
            state          <= state_nx;
            sr_cnt         <= sr_cnt_nx;
            num_data_valid <= num_nx;
            full_n_q       <= (num_nx != NUM_MAX);
            empty_n_q      <= (state_nx != EMPTY);
            if (ld_byp)     dout_q <= fifo.if_din;
            else if (ld_sr) dout_q <= sr_dout;
        end
    end

endmodule
